// File: rtl/key_multi.sv
// key_multi: N-channel debounced key press detector with ack/timeout handshake; long-press mode enabled by KEY_LONG_PRESS_EN
module key_multi #(
    parameter int N_KEY     = 4,
    parameter int DEBOUNCE  = 500_000,
    parameter int TIMEOUT   = 500_000,
    parameter int LONG_TIME = 50_000_000,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_KEY-1:0] key,
    output logic [N_KEY-1:0] fs,
    input  logic [N_KEY-1:0] fd,
    output logic [N_KEY-1:0] to,
    output logic [N_KEY-1:0] lp
);
    localparam logic [1:0]       IDLE    = 2'd0;
    localparam logic [1:0]       PRESS   = 2'd1;
    localparam logic [1:0]       WORK    = 2'd2;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);

    if (DEBOUNCE < 2 || CNT_W < $clog2(DEBOUNCE + 1) || CNT_W < $clog2(TIMEOUT + 1) ||
        CNT_W < $clog2(LONG_TIME + 1)) begin : g_bad_param
        $error("key_multi: DEBOUNCE must be >= 2 and CNT_W must hold every counter limit");
    end

    for (genvar i = 0; i < N_KEY; i++) begin : g_ch
        logic             s1_q, s2_q, filt_q, filt_d, fprev_q, to_q, to_d, fall, rise, skip;
        logic [CNT_W-1:0] dcnt_q, dcnt_d, tcnt_q, tcnt_d;
        logic [1:0]       state_q, state_d;

        assign fall  = fprev_q & ~filt_q;
        assign rise  = ~fprev_q & filt_q;
        assign fs[i] = state_q == WORK;
        assign to[i] = to_q;

        // Debouncer: filtered level follows s2 only after DEBOUNCE consecutive differing samples
        always_comb begin
            dcnt_d = (s2_q == filt_q || dcnt_q == DB_LAST) ? '0 : dcnt_q + ONE;
            filt_d = (s2_q != filt_q && dcnt_q == DB_LAST) ? s2_q : filt_q;
        end

        // Event FSM: press, release, then hold fs until ack or timeout
        always_comb begin
            state_d = IDLE;
            case (state_q)
                IDLE:    state_d = fall ? PRESS : IDLE;
                PRESS:   state_d = rise ? (skip ? IDLE : WORK) : PRESS;
                WORK:    state_d = (fd[i] || tcnt_q == TO_LAST) ? IDLE : WORK;
                default: state_d = IDLE;
            endcase
            tcnt_d = (state_q == WORK && state_d == WORK) ? tcnt_q + ONE : '0;
            to_d   = state_q == WORK && !fd[i] && tcnt_q == TO_LAST;
        end

        // Synchroniser, debouncer, edge-detect and FSM registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q    <= 1'b1;
                s2_q    <= 1'b1;
                filt_q  <= 1'b1;
                fprev_q <= 1'b1;
                dcnt_q  <= '0;
                tcnt_q  <= '0;
                state_q <= IDLE;
                to_q    <= 1'b0;
            end else begin
                s1_q    <= key[i];
                s2_q    <= s1_q;
                filt_q  <= filt_d;
                fprev_q <= filt_q;
                dcnt_q  <= dcnt_d;
                tcnt_q  <= tcnt_d;
                state_q <= state_d;
                to_q    <= to_d;
            end
        end

`ifdef KEY_LONG_PRESS_EN
        localparam logic [CNT_W-1:0] LT_SAT  = CNT_W'(LONG_TIME);
        localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LONG_TIME - 1);
        logic             long_q, long_d, lp_q, lp_d, stay_press;
        logic [CNT_W-1:0] pcnt_q, pcnt_d;

        assign skip  = long_q;
        assign lp[i] = lp_q;

        // Long-press timer: fires once per press, then saturates until PRESS is left
        always_comb begin
            stay_press = state_q == PRESS && state_d == PRESS;
            pcnt_d     = !stay_press ? '0 : (pcnt_q == LT_SAT) ? pcnt_q : pcnt_q + ONE;
            lp_d       = stay_press && pcnt_q == LT_LAST && !long_q;
            long_d     = stay_press && (long_q || lp_d);
        end

        // Long-press registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pcnt_q <= '0;
                long_q <= 1'b0;
                lp_q   <= 1'b0;
            end else begin
                pcnt_q <= pcnt_d;
                long_q <= long_d;
                lp_q   <= lp_d;
            end
        end
`else
        assign skip  = 1'b0;
        assign lp[i] = 1'b0;
`endif
    end
endmodule
